// File: rtl/universal_shift_register_if.sv
// universal_shift_register_if: start/busy/done command and data bus of the universal shift register
interface universal_shift_register_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] i;
    logic             w;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;
    modport master (output start, mode, amount, i, w, input q, serial_out, busy, done);
    modport slave (input start, mode, amount, i, w, output q, serial_out, busy, done);
endinterface

// File: rtl/universal_shift_register.sv
// universal_shift_register: load/clear/shift/rotate register executing multi-position shifts one step per clock
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input logic clk,
    input logic rst_n,
    universal_shift_register_if.slave bus
);
    localparam logic [2:0] LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3, ASR = 3'd4, ROL = 3'd5, ROR = 3'd6, CLR = 3'd7;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] q;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       lmode;
    logic             lw;
    logic             so;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] nq;
    logic             nout;
    logic             is_shift;
    always_comb begin
        nq = lmode == SHL ? {q[WIDTH-2:0], lw} :
             lmode == SHR ? {lw, q[WIDTH-1:1]} :
             lmode == ASR ? {q[WIDTH-1], q[WIDTH-1:1]} :
             lmode == ROL ? {q[WIDTH-2:0], q[WIDTH-1]} :
                            {q[0], q[WIDTH-1:1]};
        nout = (lmode == SHL || lmode == ROL) ? q[WIDTH-1] : q[0];
        is_shift = bus.mode >= SHL && bus.mode <= ROR && bus.amount != '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
            lmode <= '0;
            lw    <= 1'b0;
            so    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start && is_shift) begin
                    lmode <= bus.mode;
                    lw    <= bus.w;
                    cnt   <= bus.amount;
                    state <= SHIFT;
                    busy  <= 1'b1;
                end else if (bus.start) begin
                    q    <= bus.mode == LOAD ? bus.i : bus.mode == CLR ? '0 : q;
                    done <= 1'b1;
                end
            end else begin
                q   <= nq;
                so  <= nout;
                cnt <= cnt - 1'b1;
                // last step: return to IDLE and pulse Done in the same edge
                if (cnt == AMT_W'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end
    assign bus.q          = q;
    assign bus.serial_out = so;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed checks of load, clear, shifts, rotates, busy-drop and reset abort
module tb_universal_shift_register;
    logic clk;
    logic rst_n;
    int   total;
    int   fails;
    universal_shift_register_if #(.WIDTH(8), .AMT_W(4)) u_if ();
    universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(u_if));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic go(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d, input logic fill);
        u_if.start  = 1'b1;
        u_if.mode   = m;
        u_if.amount = a;
        u_if.i      = d;
        u_if.w      = fill;
        tick();
        u_if.start = 1'b0;
    endtask
    task automatic state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, ".q"}, 16'(u_if.q), 16'(eq));
        chk({tag, ".busy"}, 16'(u_if.busy), 16'(eb));
        chk({tag, ".done"}, 16'(u_if.done), 16'(ed));
    endtask
    initial begin
        total = 0;
        fails = 0;
        rst_n = 1'b0;
        u_if.start  = 1'($urandom);
        u_if.mode   = 3'($urandom);
        u_if.amount = 4'($urandom);
        u_if.i      = 8'($urandom);
        u_if.w      = 1'($urandom);
        tick();
        tick();
        state("reset", 8'h00, 1'b0, 1'b0);
        chk("reset.so", 16'(u_if.serial_out), 16'h0);
        rst_n = 1'b1;
        u_if.start = 1'b0;
        tick();
        state("idle", 8'h00, 1'b0, 1'b0);
        go(3'd1, 4'd0, 8'hB5, 1'b0);
        state("load", 8'hB5, 1'b0, 1'b1);
        tick();
        state("load_after", 8'hB5, 1'b0, 1'b0);
        go(3'd7, 4'd0, 8'h00, 1'b0);
        state("clear", 8'h00, 1'b0, 1'b1);
        tick();
        go(3'd1, 4'd0, 8'hB5, 1'b0);
        go(3'd5, 4'd3, 8'h00, 1'b0);
        state("rol.start", 8'hB5, 1'b1, 1'b0);
        tick();
        state("rol.1", 8'h6B, 1'b1, 1'b0);
        tick();
        state("rol.2", 8'hD6, 1'b1, 1'b0);
        tick();
        state("rol.3", 8'hAD, 1'b0, 1'b1);
        chk("rol.so", 16'(u_if.serial_out), 16'h1);
        tick();
        state("rol.after", 8'hAD, 1'b0, 1'b0);
        go(3'd1, 4'd0, 8'h90, 1'b0);
        chk("load90.so_hold", 16'(u_if.serial_out), 16'h1);
        go(3'd4, 4'd2, 8'h00, 1'b0);
        tick();
        state("asr.1", 8'hC8, 1'b1, 1'b0);
        tick();
        state("asr.2", 8'hE4, 1'b0, 1'b1);
        chk("asr.so", 16'(u_if.serial_out), 16'h0);
        go(3'd2, 4'd0, 8'h00, 1'b1);
        state("amt0", 8'hE4, 1'b0, 1'b1);
        go(3'd1, 4'd0, 8'h01, 1'b0);
        go(3'd6, 4'd9, 8'h00, 1'b0);
        for (int j = 1; j <= 9; j++) tick();
        state("ror9", 8'h80, 1'b0, 1'b1);
        chk("ror9.so", 16'(u_if.serial_out), 16'h1);
        go(3'd7, 4'd0, 8'h00, 1'b0);
        go(3'd2, 4'd10, 8'h00, 1'b1);
        state("shl.start", 8'h00, 1'b1, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            if (j == 3) begin
                u_if.start = 1'b1;
                u_if.mode  = 3'd7;
            end
            u_if.w = j[0];
            tick();
            u_if.start = 1'b0;
            if (j < 10) state($sformatf("shl.%0d", j), 8'((16'h1 << j) - 1), 1'b1, 1'b0);
        end
        state("shl.end", 8'hFF, 1'b0, 1'b1);
        go(3'd3, 4'd1, 8'h00, 1'b0);
        state("shr.start", 8'hFF, 1'b1, 1'b0);
        tick();
        state("shr.end", 8'h7F, 1'b0, 1'b1);
        chk("shr.so", 16'(u_if.serial_out), 16'h1);
        go(3'd1, 4'd0, 8'hF0, 1'b0);
        go(3'd3, 4'd5, 8'h00, 1'b0);
        tick();
        state("abort.1", 8'h78, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        state("abort.rst", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            state($sformatf("abort.post%0d", j), 8'h00, 1'b0, 1'b0);
        end
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
